rr_vc_arbiter: RTL
==================

# rr_vc_arbiter

Round-robin virtual-channel arbiter for one switch output port in the 2D-mesh VC switch. It selects one of NUM_VC requesting VCs using a rotating priority pointer, registers a one-hot grant, and holds the grant until the downstream stage accepts the packet's tail flit. It sits between the per-VC input buffers and the output crossbar/link stage and sequences access to that shared resource.

## Interface
- NUM_VC, 4, VCs per virtual network; legal range 2..16
- NUM_VN, 3, virtual networks; informational only, no effect on logic
- bits_VC, localparam Log2(NUM_VC), width of VC index
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_vc  in  NUM_VC  per-VC request; bit i set means VC i holds a flit for this port
- grant_ack  in  1  downstream accepted the granted VC's flit this cycle
- tail_flit  in  1  accepted flit is a tail; sampled only when grant_ack=1
- grant_vc  out  NUM_VC  registered one-hot grant; all zeros when no grant
- grant_valid  out  1  registered; equals OR of grant_vc
- grant_id  out  bits_VC  registered binary index of the granted VC; 0 when idle

## Operation
- State: ptr (bits_VC, highest-priority VC index), st in {IDLE, LOCKED}, plus grant registers.
- Arbitration function: rotate req_vc right by ptr, select lowest set bit, add ptr modulo NUM_VC to get the winner. Wrap-around: with ptr=3, NUM_VC=4, req=0b0101 -> winner 0.
- IDLE: if req_vc != 0, register winner into grant_vc/grant_id, set grant_valid, go LOCKED. If req_vc == 0, stay IDLE, outputs 0.
- LOCKED: grant held constant. Changes in req_vc are ignored, including deassertion of the granted VC's request.
- LOCKED, grant_ack=1 and tail_flit=0: stay LOCKED.
- LOCKED, grant_ack=1 and tail_flit=1: ptr <= (grant_id+1) mod NUM_VC. In the same edge, re-arbitrate with that new ptr over req_vc with the just-granted VC's bit masked. If a winner exists, load it and stay LOCKED (zero-bubble handover). Otherwise clear the grant and go IDLE.
- grant_ack with grant_valid=0 is ignored.
- ptr changes only on a tail acknowledge.
- Reset: ptr=0, st=IDLE, grant_vc=0, grant_valid=0, grant_id=0. Reset during a packet drops the lock immediately; the next grant comes from fresh arbitration with ptr=0.

## Timing
- Grant latency: request visible at edge N (IDLE) -> grant_valid high after edge N.
- Handover: tail acknowledged at edge N -> next VC's grant valid after edge N; no idle cycle between packets.
- Release with no other requesters: grant_valid low after the tail-ack edge.
- All outputs come directly from flops. Only the next-state path is combinational: rotate, priority encode, add.

## Configuration
- RR_VC_ARB_PKT_LOCK_EN defined: packet-level locking as described above.
- RR_VC_ARB_PKT_LOCK_EN undefined: flit-level round-robin. Every grant_ack is treated as a tail regardless of tail_flit: ptr advances and arbitration reruns on each acknowledged flit. tail_flit is unused.

## Structure
- Log2 and the VC-count constants come from the shared common-functions header. The IDLE/LOCKED state encoding goes in a shared localparam include so the switch's other arbiters reuse it.
- Sub-module rr_vc_prio_enc (combinational): inputs req and ptr; outputs winner one-hot, winner index, and any.
- The top level holds ptr, st, grant registers and the mask/handover logic.

## Test plan
- Reset, then req_vc=0b0110 -> after one edge grant_id=1, grant_vc=0b0010; ptr stays 0.
- Granted VC1, three acks with the tail on the third, req_vc=0b0110 throughout -> grant held on VC1 for all three; after the tail edge grant_id=2, ptr=2, no bubble.
- ptr=3, VC3 granted, tail ack with req_vc=0b1001 -> VC3 masked, wrap-around picks VC0; ptr=0.
- Granted VC2 drops req before its tail -> grant stays on VC2 until the tail ack, then grant_valid=0 if req_vc=0.
- rst asserted while VC1 is locked mid-packet -> next edge all outputs 0 and ptr=0; then req_vc=0b1000 -> grant_id=3.
- Build without RR_VC_ARB_PKT_LOCK_EN, req_vc=0b1111, grant_ack=1 every cycle, tail_flit=0 -> grant_id sequence 0,1,2,3,0.

Source files
------------

// File: rtl/rr_vc_arbiter_pkg.sv
// Shared definitions for the VC arbiters: VC-count defaults, log2 helper and
// the IDLE/LOCKED arbitration state encoding.
package rr_vc_arbiter_pkg;

   localparam int unsigned NUM_VC_DEFAULT = 4;
   localparam int unsigned NUM_VN_DEFAULT = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_st_e;

   // Width needed to index n items; never less than one bit.
   function automatic int unsigned vc_log2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_vc_prio_enc.sv
// Rotating-priority encoder: first set bit of req scanning upward from ptr,
// wrapping at NUM_VC.
module rr_vc_prio_enc
   import rr_vc_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_VC  = NUM_VC_DEFAULT,
   localparam int unsigned bits_VC = vc_log2(NUM_VC)
) (
   input  logic [NUM_VC-1:0]  req,
   input  logic [bits_VC-1:0] ptr,
   output logic [NUM_VC-1:0]  win_onehot,
   output logic [bits_VC-1:0] win_id,
   output logic               any
);

   logic [bits_VC:0]   sum;
   logic [bits_VC-1:0] pos;

   always_comb begin
      win_onehot = '0;
      win_id     = '0;
      any        = 1'b0;
      sum        = '0;
      pos        = '0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         sum = {1'b0, ptr} + (bits_VC+1)'(i);
         if (sum >= (bits_VC+1)'(NUM_VC)) sum = sum - (bits_VC+1)'(NUM_VC);
         pos = sum[bits_VC-1:0];
         if (!any && req[pos]) begin
            any             = 1'b1;
            win_onehot[pos] = 1'b1;
            win_id          = pos;
         end
      end
   end

endmodule

// File: rtl/rr_vc_arbiter.sv
// Round-robin VC arbiter with registered one-hot grant held until release.
// RR_VC_ARB_PKT_LOCK_EN: hold the grant for a whole packet (release on tail);
// otherwise every acknowledged flit releases and re-arbitrates.
module rr_vc_arbiter
   import rr_vc_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_VC  = NUM_VC_DEFAULT,
   parameter  int unsigned NUM_VN  = NUM_VN_DEFAULT,
   localparam int unsigned bits_VC = vc_log2(NUM_VC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_VC-1:0]  req_vc,
   input  logic               grant_ack,
   input  logic               tail_flit,
   output logic [NUM_VC-1:0]  grant_vc,
   output logic               grant_valid,
   output logic [bits_VC-1:0] grant_id
);

   localparam int unsigned unused_num_vn = NUM_VN;

   arb_st_e            st_q, st_d;
   logic [bits_VC-1:0] ptr_q, ptr_d;
   logic [NUM_VC-1:0]  grant_vc_q, grant_vc_d;
   logic [bits_VC-1:0] grant_id_q, grant_id_d;
   logic               grant_valid_q, grant_valid_d;

   logic               release_c;
   logic [bits_VC-1:0] ptr_inc;
   logic [NUM_VC-1:0]  enc_req;
   logic [bits_VC-1:0] enc_ptr;
   logic [NUM_VC-1:0]  enc_onehot;
   logic [bits_VC-1:0] enc_id;
   logic               enc_any;

`ifdef RR_VC_ARB_PKT_LOCK_EN
   assign release_c = grant_ack && tail_flit;
`else
   logic unused_tail_flit;
   assign unused_tail_flit = tail_flit;
   assign release_c        = grant_ack;
`endif

   assign ptr_inc = (grant_id_q == bits_VC'(NUM_VC-1)) ? '0 : grant_id_q + 1'b1;

   // One encoder serves both cases: fresh arbitration from IDLE, and the
   // handover pass with the advanced pointer and the outgoing VC masked.
   assign enc_req = (st_q == ST_LOCKED) ? (req_vc & ~grant_vc_q) : req_vc;
   assign enc_ptr = (st_q == ST_LOCKED) ? ptr_inc : ptr_q;

   rr_vc_prio_enc #(.NUM_VC(NUM_VC)) u_prio_enc (
      .req        (enc_req),
      .ptr        (enc_ptr),
      .win_onehot (enc_onehot),
      .win_id     (enc_id),
      .any        (enc_any)
   );

   always_comb begin
      st_d          = st_q;
      ptr_d         = ptr_q;
      grant_vc_d    = grant_vc_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      case (st_q)
         ST_IDLE: begin
            if (enc_any) begin
               st_d          = ST_LOCKED;
               grant_vc_d    = enc_onehot;
               grant_id_d    = enc_id;
               grant_valid_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (release_c) begin
               ptr_d = ptr_inc;
               if (enc_any) begin
                  grant_vc_d = enc_onehot;
                  grant_id_d = enc_id;
               end else begin
                  st_d          = ST_IDLE;
                  grant_vc_d    = '0;
                  grant_id_d    = '0;
                  grant_valid_d = 1'b0;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q          <= ST_IDLE;
         ptr_q         <= '0;
         grant_vc_q    <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         st_q          <= st_d;
         ptr_q         <= ptr_d;
         grant_vc_q    <= grant_vc_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign grant_vc    = grant_vc_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;

endmodule
